// File: rtl/sr_drv_pkg.sv
// -----------------------------------------------------------------------------
// sr_drv_pkg
// Shared types and defaults for the SR latch drive front-end.
//   sr_drv_state_t  : pulse FSM states (IDLE, SET_P, RST_P, GAP)
//   DEF_DEB_CYCLES  : default debounce length in synchronised samples
//   DEF_PULSE_W     : default s/r pulse width in cycles
//   DEF_GAP_W       : default dead-time gap after each pulse in cycles
//   DROP_CNT_W      : width of the optional discarded-event counter
// -----------------------------------------------------------------------------
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    RST_P = 2'd2,
    GAP   = 2'd3
  } sr_drv_state_t;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_PULSE_W    = 2;
  localparam int DEF_GAP_W      = 1;
  localparam int DROP_CNT_W     = 8;

endpackage

// File: rtl/sr_debounce.sv
// -----------------------------------------------------------------------------
// sr_debounce
// Two-flop synchroniser, debounce counter and rising-edge event for one raw
// asynchronous request line.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   din   in   raw request, asynchronous to clk
//   level out  debounced level
//   rise  out  one-cycle pulse in the first cycle the debounced level is high
// Parameter:
//   DEB_CYCLES : consecutive differing samples needed to flip the level (>=1)
// -----------------------------------------------------------------------------
module sr_debounce
  import sr_drv_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          rise_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchroniser for the raw asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Debounce counter; the edge event is registered on the same edge that
  // flips the level, so rise is high exactly in the first high-level cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r   <= '0;
      rise_r  <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= '0;
      level_r <= sync2_r;
      rise_r  <= sync2_r;
    end else begin
      cnt_r   <= cnt_r + CNT_ONE;
      rise_r  <= 1'b0;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/sr_drive_ctrl.sv
// -----------------------------------------------------------------------------
// sr_drive_ctrl
// Command front-end for an SR latch: debounces raw set/reset requests,
// arbitrates their rising-edge events and emits mutually exclusive,
// fixed-width s/r pulses followed by a dead-time gap.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   set_req   in   raw set request (asynchronous)
//   reset_req in   raw reset request (asynchronous)
//   s         out  registered set drive
//   r         out  registered reset drive
//   busy      out  high whenever the FSM is not IDLE
//   drop      out  one-cycle pulse when a request event is discarded
//   drop_cnt  out  saturating count of drop cycles (only with
//                  SR_DRV_DROP_CNT_EN defined)
// Parameters: DEB_CYCLES, PULSE_W (>=1), GAP_W (>=0), SET_PRIO (1: set wins).
// Optional feature macro: SR_DRV_DROP_CNT_EN
// -----------------------------------------------------------------------------
module sr_drive_ctrl
  import sr_drv_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PULSE_W    = DEF_PULSE_W,
  parameter int GAP_W      = DEF_GAP_W,
  parameter int SET_PRIO   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic reset_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic drop
`ifdef SR_DRV_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam int CW = $clog2(PULSE_W + GAP_W + 1);
  localparam logic [CW-1:0] PW_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GP_LAST = CW'((GAP_W > 0) ? (GAP_W - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic set_lvl_s;
  logic set_rise_s;
  logic rst_lvl_s;
  logic rst_rise_s;
  logic set_ev_s;
  logic rst_ev_s;

  sr_drv_state_t state_r;
  sr_drv_state_t state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          drop_nxt_s;

  logic s_r;
  logic r_r;
  logic busy_r;
  logic drop_r;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
    .clk   (clk),
    .rst   (rst),
    .din   (set_req),
    .level (set_lvl_s),
    .rise  (set_rise_s)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rst_deb (
    .clk   (clk),
    .rst   (rst),
    .din   (reset_req),
    .level (rst_lvl_s),
    .rise  (rst_rise_s)
  );

  // An event is only honoured while its debounced level agrees it is high;
  // both come from the same edge, so this is a consistency qualifier.
  assign set_ev_s = set_rise_s & set_lvl_s;
  assign rst_ev_s = rst_rise_s & rst_lvl_s;

  // Next-state, pulse counter and discard decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    drop_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = '0;
        if (set_ev_s && rst_ev_s) begin
          // Simultaneous events: the loser is discarded.
          drop_nxt_s  = 1'b1;
          state_nxt_s = (SET_PRIO != 0) ? SET_P : RST_P;
        end else if (set_ev_s) begin
          state_nxt_s = SET_P;
        end else if (rst_ev_s) begin
          state_nxt_s = RST_P;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SET_P, RST_P: begin
        // Events are never queued while a command is in flight.
        drop_nxt_s = set_ev_s | rst_ev_s;
        if (cnt_r == PW_LAST) begin
          cnt_nxt_s   = '0;
          state_nxt_s = (GAP_W > 0) ? GAP : IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      GAP: begin
        drop_nxt_s = set_ev_s | rst_ev_s;
        if (cnt_r == GP_LAST) begin
          cnt_nxt_s   = '0;
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_nxt_s   = '0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counter and output registers; outputs are decoded from the next
  // state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      s_r     <= 1'b0;
      r_r     <= 1'b0;
      busy_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      s_r     <= (state_nxt_s == SET_P);
      r_r     <= (state_nxt_s == RST_P);
      busy_r  <= (state_nxt_s != IDLE);
      drop_r  <= drop_nxt_s;
    end
  end

  assign s    = s_r;
  assign r    = r_r;
  assign busy = busy_r;
  assign drop = drop_r;

`ifdef SR_DRV_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_r;

  // Saturating discard counter; a cycle discarding two events counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= '0;
    end else if (drop_nxt_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sr_drive_ctrl
// Directed bench for sr_drive_ctrl at default parameters, with a second
// instance using SET_PRIO=1 for the arbitration case. Outputs are sampled
// 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_sr_drive_ctrl;
  import sr_drv_pkg::*;

  localparam int PULSE_W = 2;

  logic clk;
  logic rst;
  logic set_req;
  logic reset_req;
  logic s0, r0, busy0, drop0;
  logic s1, r1, busy1, drop1;
`ifdef SR_DRV_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] dcnt0;
  logic [DROP_CNT_W-1:0] dcnt1;
`endif

  int checks   = 0;
  int failures = 0;
  int s_run    = 0;
  int r_run    = 0;
  int ncyc     = 0;

  sr_drive_ctrl dut (
    .clk(clk), .rst(rst), .set_req(set_req), .reset_req(reset_req),
    .s(s0), .r(r0), .busy(busy0), .drop(drop0)
`ifdef SR_DRV_DROP_CNT_EN
    , .drop_cnt(dcnt0)
`endif
  );

  sr_drive_ctrl #(.SET_PRIO(1)) dut_p1 (
    .clk(clk), .rst(rst), .set_req(set_req), .reset_req(reset_req),
    .s(s1), .r(r1), .busy(busy1), .drop(drop1)
`ifdef SR_DRV_DROP_CNT_EN
    , .drop_cnt(dcnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check exclusivity and track pulse widths.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      s_run = 0;
      r_run = 0;
    end else begin
      chk("excl0", 32'(s0 & r0), 32'd0);
      chk("excl1", 32'(s1 & r1), 32'd0);
      if (s0) s_run++;
      else if (s_run != 0) begin
        chk("s_width", 32'(s_run), 32'(PULSE_W));
        s_run = 0;
      end
      if (r0) r_run++;
      else if (r_run != 0) begin
        chk("r_width", 32'(r_run), 32'(PULSE_W));
        r_run = 0;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    set_req   = 1'b0;
    reset_req = 1'b0;
    #2;
    chk("rst_s", 32'(s0), 32'd0);
    chk("rst_r", 32'(r0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_drop", 32'(drop0), 32'd0);
`ifdef SR_DRV_DROP_CNT_EN
    chk("rst_dcnt", 32'(dcnt0), 32'd0);
`endif
    step();
    step();
    rst = 1'b0;
    repeat (3) step();

    // 1: single set request, s at edges 6,7, busy through gap at edge 8.
    set_req = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      chk("t1_s", 32'(s0), 32'((k == 6) || (k == 7)));
      chk("t1_r", 32'(r0), 32'd0);
      chk("t1_busy", 32'(busy0), 32'((k >= 6) && (k <= 8)));
      chk("t1_drop", 32'(drop0), 32'd0);
    end
    set_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t1_fall_s", 32'(s0), 32'd0);
    end

    // 2: three-sample glitch never produces an event.
    set_req = 1'b1;
    step();
    step();
    step();
    set_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t2_s", 32'(s0), 32'd0);
      chk("t2_r", 32'(r0), 32'd0);
      chk("t2_drop", 32'(drop0), 32'd0);
    end

    // 4: reset event one cycle into the s pulse is dropped.
    set_req = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      if (k == 0) reset_req = 1'b1;
      chk("t4_s", 32'(s0), 32'((k == 6) || (k == 7)));
      chk("t4_r", 32'(r0), 32'd0);
      chk("t4_drop", 32'(drop0), 32'(k == 7));
`ifdef SR_DRV_DROP_CNT_EN
      chk("t4_dcnt", 32'(dcnt0), 32'((k >= 7) ? 1 : 0));
`endif
    end
    set_req   = 1'b0;
    reset_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t4_tail_r", 32'(r0), 32'd0);
    end

    // 3: simultaneous events; reset wins on dut, set wins on dut_p1.
    set_req   = 1'b1;
    reset_req = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      chk("t3_p0_r", 32'(r0), 32'((k == 6) || (k == 7)));
      chk("t3_p0_s", 32'(s0), 32'd0);
      chk("t3_p0_drop", 32'(drop0), 32'(k == 6));
      chk("t3_p1_s", 32'(s1), 32'((k == 6) || (k == 7)));
      chk("t3_p1_r", 32'(r1), 32'd0);
      chk("t3_p1_drop", 32'(drop1), 32'(k == 6));
    end
    set_req   = 1'b0;
    reset_req = 1'b0;
    repeat (8) step();

    // 5: asynchronous reset mid-pulse, then relaunch with set held.
    set_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
    end
    chk("t5_pre_s", 32'(s0), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_s", 32'(s0), 32'd0);
    chk("t5_async_busy", 32'(busy0), 32'd0);
    chk("t5_async_r", 32'(r0), 32'd0);
    chk("t5_async_drop", 32'(drop0), 32'd0);
    step();
    #1;
    rst = 1'b0;
`ifdef SR_DRV_DROP_CNT_EN
    chk("t5_dcnt", 32'(dcnt0), 32'd0);
`endif
    for (int k = 0; k < 11; k++) begin
      step();
      chk("t5_s", 32'(s0), 32'((k == 6) || (k == 7)));
      chk("t5_r", 32'(r0), 32'd0);
    end
    set_req = 1'b0;
    repeat (8) step();

    // 6: random hold lengths on both inputs; step() checks the invariants.
    ncyc = 0;
    while (ncyc < 10000) begin
      int hold;
      set_req   = 1'($urandom_range(0, 1));
      reset_req = 1'($urandom_range(0, 1));
      hold      = int'($urandom_range(1, 12));
      for (int k = 0; k < hold; k++) begin
        step();
      end
      ncyc += hold;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
